// File: rtl/nios_oci_pkg.sv
// -----------------------------------------------------------------------------
// nios_oci_pkg
// Shared definitions for the OCI debug-memory controller: the JTAG data word
// (jdo) field positions, the controller state encoding and the default debug
// RAM word-address width.
// -----------------------------------------------------------------------------
package nios_oci_pkg;

  localparam int RAM_AW_DEF    = 8;

  localparam int JDO_W         = 38;
  localparam int JDO_RD_BIT    = 35;
  localparam int JDO_ADDR_MSB  = 33;
  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    JRD1 = 3'd1,
    JRD2 = 3'd2,
    JWR  = 3'd3,
    CRD  = 3'd4
  } state_t;

endpackage

// File: rtl/nios_oci_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// nios_oci_mem_ctrl_if
// CPU-side memory bus of the OCI debug RAM (Avalon-style read/write with
// waitrequest).
//   cpu_address     word address into the debug RAM
//   cpu_read        read request
//   cpu_write       write request (wins when asserted together with read)
//   cpu_writedata   write data
//   cpu_byteenable  per-byte write enables
//   cpu_readdata    read data
//   cpu_waitrequest stall; the request must be held while it is high
// Modports: master (CPU side), slave (controller side).
// -----------------------------------------------------------------------------
interface nios_oci_mem_ctrl_if
  import nios_oci_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF
) ();

  logic [RAM_AW-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    input  cpu_readdata, cpu_waitrequest
  );

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    output cpu_readdata, cpu_waitrequest
  );

endinterface

// File: rtl/nios_oci_ram.sv
// -----------------------------------------------------------------------------
// nios_oci_ram
// Single-port 2^RAM_AW x 32 debug RAM with byte-enable write and synchronous
// read (one-cycle latency). Contents are never reset.
//   clk      clock
//   i_addr   word address shared by read and write
//   i_re     read enable; o_rdata updates on the next edge and then holds
//   i_be     byte-lane write enables (4'b0000 = no write)
//   i_wdata  write data
//   o_rdata  registered read data
// -----------------------------------------------------------------------------
module nios_oci_ram #(
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic [RAM_AW-1:0] i_addr,
  input  logic              i_re,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<RAM_AW)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/nios_oci_mem_ctrl.sv
// -----------------------------------------------------------------------------
// nios_oci_mem_ctrl
// Arbitrates the OCI debug RAM between the JTAG debug path and the CPU bus.
// JTAG always wins in IDLE; the CPU is stalled with waitrequest meanwhile.
//   clk                      clock
//   reset_n                  asynchronous active-low reset
//   jdo[37:0]                JTAG data word: rd=35, addr=33:26, wdata=34:3
//   take_action_ocimem_a     load MonAReg from jdo, start a read if rd=1
//   take_no_action_ocimem_a  read at current MonAReg
//   take_action_ocimem_b     write jdo wdata at current MonAReg
//   cpu                      CPU bus (slave modport)
//   MonDReg                  last JTAG read data
//   MonAReg                  current JTAG word address (auto-increments)
//   monitor_ready            JTAG read data valid
//   monitor_error            a JTAG pulse arrived while busy
// -----------------------------------------------------------------------------
module nios_oci_mem_ctrl
  import nios_oci_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [JDO_W-1:0]     jdo,
  input  logic                 take_action_ocimem_a,
  input  logic                 take_no_action_ocimem_a,
  input  logic                 take_action_ocimem_b,
  nios_oci_mem_ctrl_if.slave   cpu,
  output logic [31:0]          MonDReg,
  output logic [RAM_AW-1:0]    MonAReg,
  output logic                 monitor_ready,
  output logic                 monitor_error
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_mon_dreg;
  logic [RAM_AW-1:0] r_mon_areg;
  logic              r_ready;
  logic              r_error;
  logic [31:0]       r_cpu_rdata;
  logic [31:0]       r_jwdata;

  logic [RAM_AW-1:0] w_ram_addr;
  logic              w_ram_re;
  logic [3:0]        w_ram_be;
  logic [31:0]       w_ram_wdata;
  logic [31:0]       w_ram_rdata;

  logic              w_cpu_req;
  logic              w_jtag_any;
  logic              w_cpu_wait;
  logic              w_ld_addr;
  logic              w_ld_wdata;
  logic              w_ld_dreg;
  logic              w_inc_addr;
  logic              w_ld_cpu_rdata;
  logic              w_set_err;
  logic [7:0]        w_jdo_addr;

  assign w_cpu_req  = cpu.cpu_read | cpu.cpu_write;
  assign w_jtag_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_jdo_addr = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];

  nios_oci_ram #(.RAM_AW(RAM_AW)) u_ram (
    .clk     (clk),
    .i_addr  (w_ram_addr),
    .i_re    (w_ram_re),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_ram_addr     = r_mon_areg;
    w_ram_re       = 1'b0;
    w_ram_be       = 4'b0000;
    w_ram_wdata    = r_jwdata;
    w_cpu_wait     = 1'b0;
    w_ld_addr      = 1'b0;
    w_ld_wdata     = 1'b0;
    w_ld_dreg      = 1'b0;
    w_inc_addr     = 1'b0;
    w_ld_cpu_rdata = 1'b0;
    w_set_err      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          w_ld_addr  = 1'b1;
          w_cpu_wait = w_cpu_req;
          if (jdo[JDO_RD_BIT]) w_state_nxt = JRD1;
        end else if (take_no_action_ocimem_a) begin
          w_cpu_wait  = w_cpu_req;
          w_state_nxt = JRD1;
        end else if (take_action_ocimem_b) begin
          w_ld_wdata  = 1'b1;
          w_cpu_wait  = w_cpu_req;
          w_state_nxt = JWR;
        end else if (cpu.cpu_write) begin
          // Single-cycle CPU write; also covers read+write asserted together.
          w_ram_addr  = cpu.cpu_address;
          w_ram_be    = cpu.cpu_byteenable;
          w_ram_wdata = cpu.cpu_writedata;
        end else if (cpu.cpu_read) begin
          w_ram_addr  = cpu.cpu_address;
          w_ram_re    = 1'b1;
          w_cpu_wait  = 1'b1;
          w_state_nxt = CRD;
        end
      end
      JRD1: begin
        w_ram_re    = 1'b1;
        w_cpu_wait  = w_cpu_req;
        w_set_err   = w_jtag_any;
        w_state_nxt = JRD2;
      end
      JRD2: begin
        w_ld_dreg   = 1'b1;
        w_inc_addr  = 1'b1;
        w_cpu_wait  = w_cpu_req;
        w_set_err   = w_jtag_any;
        w_state_nxt = IDLE;
      end
      JWR: begin
        w_ram_be    = 4'b1111;
        w_inc_addr  = 1'b1;
        w_cpu_wait  = w_cpu_req;
        w_set_err   = w_jtag_any;
        w_state_nxt = IDLE;
      end
      CRD: begin
        // RAM data is valid this cycle, so the CPU read completes here.
        w_ld_cpu_rdata = 1'b1;
        w_set_err      = w_jtag_any;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_mon_dreg  <= 32'h0;
      r_mon_areg  <= '0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_rdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      // Address increment wraps naturally at the RAM_AW width.
      if (w_ld_addr)       r_mon_areg <= RAM_AW'(w_jdo_addr);
      else if (w_inc_addr) r_mon_areg <= r_mon_areg + RAM_AW'(1);
      if (w_ld_dreg)       r_mon_dreg <= w_ram_rdata;
      if (w_ld_addr)       r_ready    <= 1'b0;
      else if (w_ld_dreg)  r_ready    <= 1'b1;
      if (w_set_err)       r_error    <= 1'b1;
      else if (w_ld_addr)  r_error    <= 1'b0;
      if (w_ld_cpu_rdata)  r_cpu_rdata <= w_ram_rdata;
    end
  end

  // Write-data holding register; only meaningful while in JWR.
  always_ff @(posedge clk) begin
    if (w_ld_wdata) r_jwdata <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
  end

  assign MonDReg       = r_mon_dreg;
  assign MonAReg       = r_mon_areg;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

  assign cpu.cpu_waitrequest = w_cpu_wait;
  // During CRD the RAM output register already holds the fresh word; outside
  // CRD the held copy keeps the value stable between CPU reads.
  assign cpu.cpu_readdata    = (r_state == CRD) ? w_ram_rdata : r_cpu_rdata;

endmodule

// File: tb/tb_nios_oci_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nios_oci_mem_ctrl
// Directed testbench for nios_oci_mem_ctrl. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_nios_oci_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        act_a;
  logic        noact_a;
  logic        act_b;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready;
  logic        monitor_error;

  int n_checks = 0;
  int n_fail   = 0;

  nios_oci_mem_ctrl_if #(.RAM_AW(8)) bus ();

  nios_oci_mem_ctrl #(.RAM_AW(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (act_a),
    .take_no_action_ocimem_a (noact_a),
    .take_action_ocimem_b    (act_b),
    .cpu                     (bus),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_a(input logic rd, input logic [7:0] addr);
    jdo = 38'h0;
    jdo[35] = rd;
    jdo[33:26] = addr;
    act_a = 1'b1;
    tick();
    act_a = 1'b0;
  endtask

  task automatic pulse_n();
    noact_a = 1'b1;
    tick();
    noact_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [31:0] wdata);
    jdo = 38'h0;
    jdo[34:3] = wdata;
    act_b = 1'b1;
    tick();
    act_b = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic also_rd, input string tag);
    bus.cpu_address    = addr;
    bus.cpu_writedata  = data;
    bus.cpu_byteenable = be;
    bus.cpu_write      = 1'b1;
    bus.cpu_read       = also_rd;
    #1;
    chk(tag, 32'(bus.cpu_waitrequest), 32'h0);
    tick();
    bus.cpu_write = 1'b0;
    bus.cpu_read  = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    bus.cpu_address = addr;
    bus.cpu_read    = 1'b1;
    #1;
    chk({tag, "_wait1"}, 32'(bus.cpu_waitrequest), 32'h1);
    tick();
    chk({tag, "_wait0"}, 32'(bus.cpu_waitrequest), 32'h0);
    chk({tag, "_data"}, bus.cpu_readdata, exp);
    bus.cpu_read = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = 38'h0;
    act_a = 1'b0;
    noact_a = 1'b0;
    act_b = 1'b0;
    bus.cpu_address = 8'h0;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_writedata = 32'h0;
    bus.cpu_byteenable = 4'h0;

    // Reset state
    #2;
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_monareg", 32'(MonAReg), 32'h0);
    chk("rst_ready",   32'(monitor_ready), 32'h0);
    chk("rst_error",   32'(monitor_error), 32'h0);
    chk("rst_cpurd",   bus.cpu_readdata, 32'h0);
    chk("rst_wait",    32'(bus.cpu_waitrequest), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // JTAG write then read-back at 0x10
    pulse_a(1'b0, 8'h10);
    chk("ld_addr", 32'(MonAReg), 32'h10);
    pulse_b(32'hDEADBEEF);
    tick();
    chk("wr_inc", 32'(MonAReg), 32'h11);
    pulse_a(1'b1, 8'h10);
    chk("rd_c1_ready", 32'(monitor_ready), 32'h0);
    tick();
    tick();
    chk("rd_data",  MonDReg, 32'hDEADBEEF);
    chk("rd_ready", 32'(monitor_ready), 32'h1);
    chk("rd_inc",   32'(MonAReg), 32'h11);

    // Address wrap 0xFF -> 0x00
    pulse_a(1'b0, 8'hFF);
    pulse_b(32'hA5A50FF0);
    tick();
    chk("wrap_wr", 32'(MonAReg), 32'h00);
    pulse_b(32'h12345678);
    tick();
    chk("wrap_wr2", 32'(MonAReg), 32'h01);
    pulse_a(1'b1, 8'hFF);
    tick();
    tick();
    chk("wrap_rd_ff",  MonDReg, 32'hA5A50FF0);
    chk("wrap_rd_a0",  32'(MonAReg), 32'h00);
    pulse_n();
    tick();
    tick();
    chk("wrap_rd_00",  MonDReg, 32'h12345678);
    chk("wrap_rd_a1",  32'(MonAReg), 32'h01);
    chk("wrap_noerr",  32'(monitor_error), 32'h0);

    // Overlapping pulse during JRD1
    pulse_a(1'b1, 8'h10);
    noact_a = 1'b1;
    tick();
    noact_a = 1'b0;
    chk("ovl_err", 32'(monitor_error), 32'h1);
    tick();
    chk("ovl_data",  MonDReg, 32'hDEADBEEF);
    chk("ovl_ready", 32'(monitor_ready), 32'h1);
    tick();
    tick();
    chk("ovl_once",  32'(MonAReg), 32'h11);
    chk("ovl_stick", 32'(monitor_error), 32'h1);
    pulse_a(1'b0, 8'h20);
    chk("ovl_clr",   32'(monitor_error), 32'h0);

    // Collision: JTAG write and CPU write to 0x20 in the same cycle
    jdo = 38'h0;
    jdo[34:3] = 32'h11111111;
    act_b = 1'b1;
    bus.cpu_address = 8'h20;
    bus.cpu_writedata = 32'h22222222;
    bus.cpu_byteenable = 4'hF;
    bus.cpu_write = 1'b1;
    #1;
    chk("col_wait_c0", 32'(bus.cpu_waitrequest), 32'h1);
    tick();
    act_b = 1'b0;
    #1;
    chk("col_wait_c1", 32'(bus.cpu_waitrequest), 32'h1);
    tick();
    chk("col_wait_c2", 32'(bus.cpu_waitrequest), 32'h0);
    tick();
    bus.cpu_write = 1'b0;
    chk("col_areg", 32'(MonAReg), 32'h21);
    cpu_rd(8'h20, 32'h22222222, "col_rd");

    // CPU byte-lane write (first write also asserts read: treated as write)
    cpu_wr(8'h40, 32'hFFFFFFFF, 4'hF, 1'b1, "bw_wr1_wait");
    cpu_wr(8'h40, 32'h00000000, 4'b0010, 1'b0, "bw_wr2_wait");
    cpu_rd(8'h40, 32'hFFFF00FF, "bw_rd");

    // CPU readdata stays put across a JTAG read
    pulse_a(1'b1, 8'h20);
    tick();
    tick();
    chk("stable_jtag", MonDReg, 32'h22222222);
    chk("stable_cpu",  bus.cpu_readdata, 32'hFFFF00FF);

    // Reset during JRD2
    pulse_a(1'b1, 8'h10);
    tick();
    reset_n = 1'b0;
    #1;
    chk("mrst_dreg",  MonDReg, 32'h0);
    chk("mrst_areg",  32'(MonAReg), 32'h0);
    chk("mrst_ready", 32'(monitor_ready), 32'h0);
    chk("mrst_cpurd", bus.cpu_readdata, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("mrst_noinc", 32'(MonAReg), 32'h0);
    chk("mrst_nordy", 32'(monitor_ready), 32'h0);
    pulse_a(1'b1, 8'h10);
    tick();
    tick();
    chk("mrst_keep", MonDReg, 32'hDEADBEEF);
    chk("mrst_areg2", 32'(MonAReg), 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_oci_mem_ctrl.md
NIOS_OCI_MEM_CTRL -- requirements
Module: nios_oci_mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 8: debug RAM word-address width, giving a depth of 2^RAM_AW x 32 bits.
REQ-002 SHALL have one clock and one asynchronous, active-low reset: clk in 1, the only clock; reset_n in 1, async active-low reset.
REQ-003 SHALL have port jdo, in, 38: JTAG data word from the sysclk debug stage.
REQ-004 SHALL have port take_action_ocimem_a, in, 1: one-cycle pulse to load the address and optionally start a read.
REQ-005 SHALL have port take_no_action_ocimem_a, in, 1: one-cycle pulse for a continuation read at the current address.
REQ-006 SHALL have port take_action_ocimem_b, in, 1: one-cycle pulse for a JTAG write at the current address.
REQ-007 SHALL have these CPU ports: cpu_address in RAM_AW; cpu_read in 1; cpu_write in 1; cpu_writedata in 32; cpu_byteenable in 4.
REQ-008 SHALL have CPU outputs cpu_readdata out 32 (read data) and cpu_waitrequest out 1 (stall).
REQ-009 SHALL have debug outputs MonDReg out 32 (JTAG read data, feeds the JTAG capture path), MonAReg out RAM_AW (current JTAG word address), monitor_ready out 1 and monitor_error out 1.

Function
REQ-010 SHALL implement the states IDLE, JRD1, JRD2, JWR and CRD; the RAM is single-port with synchronous read and 1-cycle read latency.
REQ-011 SHALL, on take_action_ocimem_a in IDLE: MonAReg<=jdo[33:26], monitor_ready<=0, monitor_error<=0; if jdo[35]=1 the next state is JRD1, else it stays IDLE.
REQ-012 SHALL, on take_no_action_ocimem_a in IDLE, go to JRD1 without changing MonAReg.
REQ-013 SHALL, in JRD1, issue a RAM read at MonAReg; in JRD2, load MonDReg with the RAM data, set monitor_ready=1 and MonAReg<=MonAReg+1, then return to IDLE; MonDReg is therefore valid 3 cycles after the pulse.
REQ-014 SHALL, on take_action_ocimem_b in IDLE, latch jdo[34:3] and go to JWR; in JWR, write all 4 bytes at MonAReg, set MonAReg<=MonAReg+1 and return to IDLE.
REQ-015 SHALL wrap MonAReg modulo 2^RAM_AW (2^RAM_AW-1 -> 0), with no error.
REQ-016 SHALL, for any JTAG pulse arriving in a state other than IDLE, ignore it and set monitor_error=1; monitor_error stays set until the next accepted take_action_ocimem_a.
REQ-017 SHALL give JTAG priority: a JTAG pulse and a CPU request in the same IDLE cycle grant JTAG, and the CPU sees cpu_waitrequest=1.
REQ-018 SHALL hold cpu_waitrequest=1 whenever the state is not IDLE and a CPU request is present.
REQ-019 SHALL, for a CPU write granted in IDLE, write byte lanes per cpu_byteenable in the same cycle, with cpu_waitrequest=0.
REQ-020 SHALL, for a CPU read granted in IDLE, issue the RAM read with cpu_waitrequest=1 and go to CRD; in CRD, drive cpu_readdata with the RAM data, set cpu_waitrequest=0 and return to IDLE.
REQ-021 SHALL treat cpu_read and cpu_write asserted together as a write.
REQ-022 SHALL keep cpu_readdata stable between CPU reads.
REQ-023 SHALL keep cpu_waitrequest combinational from the state and requests, while all other outputs are registered.

Reset
REQ-024 SHALL, on reset_n=0, immediately set: state IDLE; MonDReg=0; MonAReg=0; monitor_ready=0; monitor_error=0; cpu_readdata=0; any pending JTAG or CPU operation discarded.
REQ-025 SHALL NOT reset RAM contents; they are undefined after power-up and preserved across reset_n.
REQ-026 SHALL treat a JTAG pulse coincident with the reset_n deassertion edge as lost.

Structure
REQ-027 SHALL place the jdo field positions (addr 33:26, rd 35, wdata 34:3), the state enum and the default RAM_AW in shared package nios_oci_pkg.
REQ-028 SHALL instantiate the RAM as one sub-module, nios_oci_ram (single-port, byte-enable write, synchronous read, parameter RAM_AW), with no other sub-modules.

Verification
REQ-029 SHALL verify the JTAG write/read-back sequence: action_a with addr=0x10, rd=0; then action_b with wdata=0xDEADBEEF; then action_a with addr=0x10, rd=1 -> MonDReg=0xDEADBEEF and monitor_ready=1 three cycles after the last pulse, with MonAReg=0x11.
REQ-030 SHALL verify the wrap: action_a with addr=0xFF, rd=1, followed by no_action_a -> the second read returns word 0x00, and MonAReg goes 0x00 then 0x01.
REQ-031 SHALL verify a collision: a CPU write to 0x20 in the same cycle as an action_b pulse -> cpu_waitrequest=1 for 2 cycles; both writes land and the JTAG write completes first.
REQ-032 SHALL verify a CPU byte write: write 0xFFFFFFFF, then a write with byteenable=4'b0010 and data 0x00000000 to the same word, then read -> 0xFFFF00FF after 1 wait cycle.
REQ-033 SHALL verify overlap: no_action_a during JRD1 -> monitor_error=1, and the read still completes once; the next action_a clears the error.
REQ-034 SHALL verify reset mid-operation: reset_n low during JRD2 -> outputs are 0 immediately, no MonAReg increment, and RAM word 0x10 still holds 0xDEADBEEF after reset.
